lcm_seq: RTL and testbench

Sequential least-common-multiple unit, the widening counterpart to the team's binary GCD block. It takes two unsigned operands on a start pulse and first reduces them with a binary (Stein) GCD loop. It then divides one operand by the GCD and multiplies the quotient by the other operand, giving lcm = (a/g)*b at full 2*WIDTH precision. It sits beside the GCD block in the arithmetic datapath and uses a start/busy/done handshake.

---
 rtl/lcm_seq.sv | 232 +++++++++++++++++++++++
 tb/tb_lcm_seq.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/lcm_seq.sv
// lcm_seq: sequential least-common-multiple unit.
// Reduces the operands with a binary (Stein) GCD loop, divides A by the GCD
// with a restoring divider, then multiplies the quotient by B with a
// shift-add multiplier to produce lcm = (a/g)*b at 2*WIDTH bits.
// Handshake: start (sampled in IDLE), busy while working, one-cycle done.

module lcm_seq #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   gcd,
   output logic [2*WIDTH-1:0] lcm
);

   // Width of the power-of-two exponent k and of the per-phase bit counter.
   localparam int KW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam int CW = KW;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_GCD  = 3'd1;
   localparam logic [2:0] S_DIV  = 3'd2;
   localparam logic [2:0] S_MUL  = 3'd3;
   localparam logic [2:0] S_FIN  = 3'd4;

   logic [2:0]         state_q,  state_d;
   logic [WIDTH-1:0]   opA_q,    opA_d;
   logic [WIDTH-1:0]   opB_q,    opB_d;
   logic [WIDTH-1:0]   a0_q,     a0_d;
   logic [WIDTH-1:0]   b0_q,     b0_d;
   logic [KW-1:0]      k_q,      k_d;
   logic [WIDTH-1:0]   g_q,      g_d;
   logic [WIDTH-1:0]   rem_q,    rem_d;
   logic [WIDTH-1:0]   quot_q,   quot_d;
   logic [2*WIDTH-1:0] mcand_q,  mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [2*WIDTH-1:0] acc_q,    acc_d;
   logic [CW-1:0]      cnt_q,    cnt_d;
   logic               busy_q,   busy_d;
   logic               done_q,   done_d;
   logic [WIDTH-1:0]   gcd_q,    gcd_d;
   logic [2*WIDTH-1:0] lcm_q,    lcm_d;

   logic [WIDTH-1:0]   steinA;
   logic [WIDTH-1:0]   steinB;
   logic [KW-1:0]      steinK;
   logic [WIDTH:0]     remShift;
   logic [WIDTH-1:0]   remDiff;
   logic               divFits;
   logic [2*WIDTH-1:0] accSum;

   // One Stein reduction step on the working operands; the GCD state uses the
   // result both to advance and to detect convergence without an extra cycle.
   always_comb begin
      steinA = opA_q;
      steinB = opB_q;
      steinK = k_q;
      if (!opA_q[0] && !opB_q[0]) begin
         steinA = opA_q >> 1;
         steinB = opB_q >> 1;
         steinK = k_q + 1'b1;
      end else if (!opB_q[0]) begin
         steinB = opB_q >> 1;
      end else if (!opA_q[0]) begin
         steinA = opA_q >> 1;
      end else if (opA_q > opB_q) begin
         steinA = (opA_q - opB_q) >> 1;
      end else begin
         steinB = (opB_q - opA_q) >> 1;
      end
   end

   // Restoring-division and shift-add datapath terms for the current cycle.
   // A successful subtraction leaves a value below g, so WIDTH bits suffice.
   always_comb begin
      remShift = {rem_q, quot_q[WIDTH-1]};
      divFits  = (remShift >= {1'b0, g_q});
      remDiff  = remShift[WIDTH-1:0] - g_q;
      accSum   = acc_q + (mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}});
   end

   // Sequencer: operand capture, Stein loop, division, multiply, result commit.
   always_comb begin
      state_d  = state_q;
      opA_d    = opA_q;
      opB_d    = opB_q;
      a0_d     = a0_q;
      b0_d     = b0_q;
      k_d      = k_q;
      g_d      = g_q;
      rem_d    = rem_q;
      quot_d   = quot_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      gcd_d    = gcd_q;
      lcm_d    = lcm_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               opA_d  = a;
               opB_d  = b;
               a0_d   = a;
               b0_d   = b;
               k_d    = '0;
               acc_d  = '0;
               cnt_d  = '0;
               busy_d = 1'b1;
               if ((a == '0) || (b == '0)) begin
                  g_d     = a | b;
                  state_d = S_FIN;
               end else if (a == b) begin
                  // Already converged: zero Stein steps, straight to division.
                  g_d     = a;
                  rem_d   = '0;
                  quot_d  = a;
                  state_d = S_DIV;
               end else begin
                  state_d = S_GCD;
               end
            end
         end

         S_GCD: begin
            opA_d = steinA;
            opB_d = steinB;
            k_d   = steinK;
            if (steinA == steinB) begin
               g_d     = steinA << steinK;
               rem_d   = '0;
               quot_d  = a0_q;
               cnt_d   = '0;
               state_d = S_DIV;
            end
         end

         S_DIV: begin
            rem_d  = divFits ? remDiff : remShift[WIDTH-1:0];
            quot_d = {quot_q[WIDTH-2:0], divFits};
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               mcand_d  = {{WIDTH{1'b0}}, quot_q[WIDTH-2:0], divFits};
               mplier_d = b0_q;
               acc_d    = '0;
               cnt_d    = '0;
               state_d  = S_MUL;
            end
         end

         S_MUL: begin
            acc_d    = accSum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = S_FIN;
            end
         end

         S_FIN: begin
            gcd_d   = g_q;
            lcm_d   = acc_q;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end

         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   // State and result registers; reset abandons any computation in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         opA_q    <= '0;
         opB_q    <= '0;
         a0_q     <= '0;
         b0_q     <= '0;
         k_q      <= '0;
         g_q      <= '0;
         rem_q    <= '0;
         quot_q   <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         gcd_q    <= '0;
         lcm_q    <= '0;
      end else begin
         state_q  <= state_d;
         opA_q    <= opA_d;
         opB_q    <= opB_d;
         a0_q     <= a0_d;
         b0_q     <= b0_d;
         k_q      <= k_d;
         g_q      <= g_d;
         rem_q    <= rem_d;
         quot_q   <= quot_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         gcd_q    <= gcd_d;
         lcm_q    <= lcm_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign gcd  = gcd_q;
   assign lcm  = lcm_q;

endmodule

// File: tb/tb_lcm_seq.sv
// tb_lcm_seq: directed self-checking bench for lcm_seq (WIDTH=8).
// Latency is counted in rising edges with the edge that samples start as 1.

module tb_lcm_seq;

   localparam int WIDTH = 8;

   logic               clk;
   logic               rst;
   logic               start;
   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   b;
   logic               busy;
   logic               done;
   logic [WIDTH-1:0]   gcd;
   logic [2*WIDTH-1:0] lcm;

   int   checks;
   int   errors;
   int   edges;
   logic busyLow;
   logic doneSeen;

   lcm_seq #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .gcd   (gcd),
      .lcm   (lcm)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic [WIDTH-1:0] opA, input logic [WIDTH-1:0] opB);
      @(negedge clk);
      a     = opA;
      b     = opB;
      start = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      edges   = 1;
      busyLow = 1'b0;
   endtask

   task automatic waitDone(input int budget);
      while ((done !== 1'b1) && (edges < budget)) begin
         if (busy !== 1'b1) busyLow = 1'b1;
         @(negedge clk);
         edges++;
      end
   endtask

   task automatic checkResult(input string tag, input logic [WIDTH-1:0] expG,
                              input logic [2*WIDTH-1:0] expL, input int expLat);
      checkOutput({tag, "_done"},       32'(done),    32'd1);
      checkOutput({tag, "_latency"},    32'(edges),   32'(expLat));
      checkOutput({tag, "_busyHeld"},   32'(busyLow), 32'd0);
      checkOutput({tag, "_busyAtDone"}, 32'(busy),    32'd0);
      checkOutput({tag, "_gcd"},        32'(gcd),     32'(expG));
      checkOutput({tag, "_lcm"},        32'(lcm),     32'(expL));
      @(negedge clk);
      checkOutput({tag, "_donePulse"},  32'(done),    32'd0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      edges  = 0;
      busyLow  = 1'b0;
      doneSeen = 1'b0;
      rst   = 1'b0;
      start = 1'b0;
      a     = '0;
      b     = '0;

      repeat (2) @(negedge clk);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_done", 32'(done), 32'd0);
      checkOutput("reset_gcd",  32'(gcd),  32'd0);
      checkOutput("reset_lcm",  32'(lcm),  32'd0);
      rst = 1'b1;
      @(negedge clk);

      // 12,18: three Stein steps, g = 3<<1 = 6, lcm = 2*18.
      applyStimulus(8'd12, 8'd18);
      waitDone(100);
      checkResult("a12_b18", 8'd6, 16'd36, 21);

      // 255,254: fourteen Stein steps, coprime, largest product.
      applyStimulus(8'd255, 8'd254);
      waitDone(100);
      checkResult("a255_b254", 8'd1, 16'hFD02, 32);

      // Zero-operand shortcut.
      applyStimulus(8'd0, 8'd9);
      waitDone(100);
      checkResult("a0_b9", 8'd9, 16'd0, 2);

      applyStimulus(8'd0, 8'd0);
      waitDone(100);
      checkResult("a0_b0", 8'd0, 16'd0, 2);

      // Equal operands: no Stein steps.
      applyStimulus(8'd128, 8'd128);
      waitDone(100);
      checkResult("a128_b128", 8'd128, 16'd128, 18);

      // 48,36 with a second start while busy; previous results must hold.
      applyStimulus(8'd48, 8'd36);
      a     = 8'd5;
      b     = 8'd7;
      start = 1'b1;
      @(negedge clk);
      edges++;
      @(negedge clk);
      edges++;
      start = 1'b0;
      checkOutput("busy_restart_busy", 32'(busy), 32'd1);
      checkOutput("busy_hold_gcd",     32'(gcd),  32'd128);
      checkOutput("busy_hold_lcm",     32'(lcm),  32'd128);
      waitDone(100);
      checkResult("a48_b36", 8'd12, 16'd144, 23);
      doneSeen = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (done === 1'b1) doneSeen = 1'b1;
      end
      checkOutput("ignored_start_no_done", 32'(doneSeen), 32'd0);

      // Reset in the middle of the multiply phase.
      applyStimulus(8'd100, 8'd75);
      while (edges < 15) begin
         @(negedge clk);
         edges++;
      end
      checkOutput("pre_reset_busy", 32'(busy), 32'd1);
      #2 rst = 1'b0;
      #1;
      checkOutput("async_reset_gcd",  32'(gcd),  32'd0);
      checkOutput("async_reset_lcm",  32'(lcm),  32'd0);
      checkOutput("async_reset_busy", 32'(busy), 32'd0);
      checkOutput("async_reset_done", 32'(done), 32'd0);
      doneSeen = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (done === 1'b1) doneSeen = 1'b1;
      end
      rst = 1'b1;
      repeat (25) begin
         @(negedge clk);
         if (done === 1'b1) doneSeen = 1'b1;
      end
      checkOutput("abort_no_done", 32'(doneSeen), 32'd0);
      checkOutput("abort_idle_busy", 32'(busy), 32'd0);

      applyStimulus(8'd100, 8'd75);
      waitDone(100);
      checkResult("a100_b75", 8'd25, 16'd300, 21);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
